// File: rtl/merge_n_pkg.sv
// Shared types and constants for the N-input merge block.
// Holds the select-mode FSM states and the MODE encodings.
package merge_n_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

endpackage

// File: rtl/merge_n_rr_arbiter.sv
// Round-robin arbiter: grants the first request found scanning upward from
// the pointer, wrapping modulo NUM_IN. Purely combinational.
module rr_arbiter
    import merge_n_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [NUM_IN-1:0] o_grant,
    output logic [SEL_W-1:0]  o_gidx
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [SEL_W:0] w_idx;
    logic           w_found;

    always_comb begin
        o_grant = '0;
        o_gidx  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_idx = {1'b0, i_ptr} + (SEL_W+1)'(i);
            if (w_idx >= (SEL_W+1)'(NUM_IN)) begin
                w_idx = w_idx - (SEL_W+1)'(NUM_IN);
            end
            if (!w_found && i_req[w_idx[SEL_W-1:0]]) begin
                w_found                   = 1'b1;
                o_grant[w_idx[SEL_W-1:0]] = 1'b1;
                o_gidx                    = w_idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/merge_n.sv
// N-input merge into a single registered output, either steered by select
// tokens (MODE 0) or by round-robin arbitration across inputs (MODE 1).
module merge_n
    import merge_n_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    input  logic [SEL_W-1:0]        sel_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    sel_err
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_src;
    logic              r_sel_err;

    logic              w_out_free;
    logic [NUM_IN-1:0] w_in_ready;
    logic              w_sel_ready;
    logic              w_sel_err_set;
    logic              w_load;
    logic [SEL_W-1:0]  w_load_idx;
    logic [WIDTH-1:0]  w_load_data;

    assign w_out_free = !r_out_valid || out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0]  r_ptr;
        logic [NUM_IN-1:0] w_rr_grant;
        logic [SEL_W-1:0]  w_rr_gidx;
        logic              w_unused_sel;

        rr_arbiter #(
            .NUM_IN (NUM_IN),
            .SEL_W  (SEL_W)
        ) u_rr_arbiter (
            .i_req   (in_valid),
            .i_ptr   (r_ptr),
            .o_grant (w_rr_grant),
            .o_gidx  (w_rr_gidx)
        );

        assign w_unused_sel  = ^{sel_valid, sel_data};
        assign w_in_ready    = (!reset && w_out_free) ? w_rr_grant : '0;
        assign w_sel_ready   = 1'b0;
        assign w_sel_err_set = 1'b0;
        assign w_load_idx    = w_rr_gidx;

        // Pointer moves one past the winner, so the winner has lowest priority next.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ptr <= '0;
            end else if (w_load) begin
                r_ptr <= (w_rr_gidx == SEL_W'(NUM_IN - 1)) ? '0 : w_rr_gidx + SEL_W'(1);
            end
        end
    end else begin : g_sel
        state_t           r_state;
        logic [SEL_W-1:0] r_gidx;
        logic             w_bad_tok;

        assign w_bad_tok     = ({1'b0, sel_data} >= (SEL_W+1)'(NUM_IN));
        assign w_sel_ready   = !reset && (r_state == IDLE);
        assign w_sel_err_set = sel_valid && w_sel_ready && w_bad_tok;
        assign w_load_idx    = r_gidx;

        always_comb begin
            w_in_ready = '0;
            if (!reset && (r_state == GRANT) && w_out_free) begin
                w_in_ready[r_gidx] = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= IDLE;
                r_gidx  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (sel_valid && !w_bad_tok) begin
                            r_gidx  <= sel_data;
                            r_state <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (w_load) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_load = |(in_valid & w_in_ready);

    always_comb begin
        w_load_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_load_idx == SEL_W'(i)) begin
                w_load_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A load while the old word drains overwrites it and keeps out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= w_sel_err_set;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
                r_out_src   <= w_load_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sel_ready = w_sel_ready;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_merge_n.sv
// Directed bench for merge_n: select mode (4 and 3 inputs) and round-robin
// mode (4 inputs) instances driven side by side from one clock and reset.
module tb_merge_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   tests = 0;
    int   fails = 0;

    // Select mode, 4 inputs
    logic        s0_sel_valid, s0_sel_ready, s0_out_valid, s0_out_ready, s0_sel_err;
    logic [1:0]  s0_sel_data, s0_out_src;
    logic [3:0]  s0_in_valid, s0_in_ready;
    logic [31:0] s0_in_data;
    logic [7:0]  s0_out_data;

    // Select mode, 3 inputs
    logic        s3_sel_valid, s3_sel_ready, s3_out_valid, s3_out_ready, s3_sel_err;
    logic [1:0]  s3_sel_data, s3_out_src;
    logic [2:0]  s3_in_valid, s3_in_ready;
    logic [23:0] s3_in_data;
    logic [7:0]  s3_out_data;

    // Round-robin mode, 4 inputs
    logic        s1_sel_valid, s1_sel_ready, s1_out_valid, s1_out_ready, s1_sel_err;
    logic [1:0]  s1_sel_data, s1_out_src;
    logic [3:0]  s1_in_valid, s1_in_ready;
    logic [31:0] s1_in_data;
    logic [7:0]  s1_out_data;

    merge_n #(.WIDTH(8), .NUM_IN(4), .MODE(0)) u_sel4 (
        .clk(clk), .reset(reset),
        .sel_valid(s0_sel_valid), .sel_ready(s0_sel_ready), .sel_data(s0_sel_data),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .out_src(s0_out_src), .sel_err(s0_sel_err)
    );

    merge_n #(.WIDTH(8), .NUM_IN(3), .MODE(0)) u_sel3 (
        .clk(clk), .reset(reset),
        .sel_valid(s3_sel_valid), .sel_ready(s3_sel_ready), .sel_data(s3_sel_data),
        .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_data(s3_in_data),
        .out_valid(s3_out_valid), .out_ready(s3_out_ready), .out_data(s3_out_data),
        .out_src(s3_out_src), .sel_err(s3_sel_err)
    );

    merge_n #(.WIDTH(8), .NUM_IN(4), .MODE(1)) u_rr4 (
        .clk(clk), .reset(reset),
        .sel_valid(s1_sel_valid), .sel_ready(s1_sel_ready), .sel_data(s1_sel_data),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
        .out_src(s1_out_src), .sel_err(s1_sel_err)
    );

    // Input consumption per channel and releases of the 8'hA5 word on u_sel4
    int cnt0 [4];
    int a5_rel = 0;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (s0_in_valid[i] && s0_in_ready[i]) cnt0[i] <= cnt0[i] + 1;
        end
        if (s0_out_valid && s0_out_ready && s0_out_data == 8'hA5) a5_rel <= a5_rel + 1;
    end

    logic [1:0] toks [3] = '{2'd2, 2'd0, 2'd3};
    int         exp_cnt [4] = '{1, 0, 1, 1};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s0_sel_valid = 1'b1; s3_sel_valid = 1'b1; s1_in_valid = 4'hF;
        cyc();
        tests++; if (s0_sel_ready !== 1'b0) begin fails++; $display("FAIL rst_sel_ready got=%0h exp=0", s0_sel_ready); end
        tests++; if (s3_sel_ready !== 1'b0) begin fails++; $display("FAIL rst_sel_ready3 got=%0h exp=0", s3_sel_ready); end
        tests++; if (s1_in_ready !== 4'h0) begin fails++; $display("FAIL rst_rr_in_ready got=%0h exp=0", s1_in_ready); end
        cyc();
        s0_sel_valid = 1'b0; s3_sel_valid = 1'b0; s1_in_valid = 4'h0;
        reset = 1'b0;
        #1;
        tests++; if (s0_out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%0h exp=0", s0_out_valid); end
        tests++; if (s0_out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data got=%0h exp=0", s0_out_data); end
        tests++; if (s0_out_src !== 2'd0) begin fails++; $display("FAIL rst_out_src got=%0h exp=0", s0_out_src); end
        tests++; if (s0_sel_err !== 1'b0) begin fails++; $display("FAIL rst_sel_err got=%0h exp=0", s0_sel_err); end
        tests++; if (s1_out_valid !== 1'b0) begin fails++; $display("FAIL rst_rr_out_valid got=%0h exp=0", s1_out_valid); end
        tests++; if (s1_sel_ready !== 1'b0) begin fails++; $display("FAIL rr_sel_ready got=%0h exp=0", s1_sel_ready); end
        tests++; if (s0_sel_ready !== 1'b1) begin fails++; $display("FAIL idle_sel_ready got=%0h exp=1", s0_sel_ready); end
    endtask

    task automatic test_select();
        s0_in_valid = 4'hF; s0_in_data = 32'h13121110; s0_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s0_sel_valid = 1'b1; s0_sel_data = toks[k];
            #1;
            tests++; if (s0_sel_ready !== 1'b1) begin fails++; $display("FAIL sel_idle_ready[%0d] got=%0h exp=1", k, s0_sel_ready); end
            tests++; if (s0_in_ready !== 4'h0) begin fails++; $display("FAIL sel_idle_in_ready[%0d] got=%0h exp=0", k, s0_in_ready); end
            cyc();
            s0_sel_valid = 1'b0;
            #1;
            tests++; if (s0_in_ready !== 4'(1 << toks[k])) begin fails++; $display("FAIL sel_grant[%0d] got=%0h exp=%0h", k, s0_in_ready, 4'(1 << toks[k])); end
            tests++; if (s0_sel_ready !== 1'b0) begin fails++; $display("FAIL sel_grant_sel_ready[%0d] got=%0h exp=0", k, s0_sel_ready); end
            cyc();
            tests++; if (s0_out_valid !== 1'b1) begin fails++; $display("FAIL sel_out_valid[%0d] got=%0h exp=1", k, s0_out_valid); end
            tests++; if (s0_out_data !== 8'h10 + 8'(toks[k])) begin fails++; $display("FAIL sel_out_data[%0d] got=%0h exp=%0h", k, s0_out_data, 8'h10 + 8'(toks[k])); end
            tests++; if (s0_out_src !== toks[k]) begin fails++; $display("FAIL sel_out_src[%0d] got=%0h exp=%0h", k, s0_out_src, toks[k]); end
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (cnt0[i] !== exp_cnt[i]) begin fails++; $display("FAIL sel_consumed[%0d] got=%0d exp=%0d", i, cnt0[i], exp_cnt[i]); end
        end
    endtask

    task automatic test_bad_token();
        s3_in_valid = 3'b111; s3_in_data = 24'h222120; s3_out_ready = 1'b1;
        s3_sel_valid = 1'b1; s3_sel_data = 2'd3;
        #1;
        tests++; if (s3_sel_ready !== 1'b1) begin fails++; $display("FAIL bad_sel_ready got=%0h exp=1", s3_sel_ready); end
        cyc();
        s3_sel_valid = 1'b0;
        #1;
        tests++; if (s3_sel_err !== 1'b1) begin fails++; $display("FAIL bad_sel_err got=%0h exp=1", s3_sel_err); end
        tests++; if (s3_in_ready !== 3'b000) begin fails++; $display("FAIL bad_in_ready got=%0h exp=0", s3_in_ready); end
        tests++; if (s3_sel_ready !== 1'b1) begin fails++; $display("FAIL bad_back_idle got=%0h exp=1", s3_sel_ready); end
        cyc();
        tests++; if (s3_sel_err !== 1'b0) begin fails++; $display("FAIL bad_err_pulse got=%0h exp=0", s3_sel_err); end
        tests++; if (s3_in_ready !== 3'b000) begin fails++; $display("FAIL bad_in_ready2 got=%0h exp=0", s3_in_ready); end
        s3_sel_valid = 1'b1; s3_sel_data = 2'd1;
        cyc();
        s3_sel_valid = 1'b0;
        #1;
        tests++; if (s3_in_ready !== 3'b010) begin fails++; $display("FAIL bad_next_grant got=%0h exp=2", s3_in_ready); end
        tests++; if (s3_sel_err !== 1'b0) begin fails++; $display("FAIL bad_next_err got=%0h exp=0", s3_sel_err); end
        cyc();
        tests++; if (s3_out_valid !== 1'b1) begin fails++; $display("FAIL bad_next_valid got=%0h exp=1", s3_out_valid); end
        tests++; if (s3_out_data !== 8'h21) begin fails++; $display("FAIL bad_next_data got=%0h exp=21", s3_out_data); end
        tests++; if (s3_out_src !== 2'd1) begin fails++; $display("FAIL bad_next_src got=%0h exp=1", s3_out_src); end
    endtask

    task automatic test_backpressure();
        s0_in_data = 32'h1312A510;
        s0_sel_valid = 1'b1; s0_sel_data = 2'd1;
        cyc();
        s0_sel_valid = 1'b0;
        #1;
        tests++; if (s0_in_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant got=%0h exp=2", s0_in_ready); end
        cyc();
        tests++; if (s0_out_data !== 8'hA5) begin fails++; $display("FAIL bp_load got=%0h exp=a5", s0_out_data); end
        s0_out_ready = 1'b0;
        s0_sel_valid = 1'b1; s0_sel_data = 2'd3;
        cyc();
        s0_sel_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (s0_out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got=%0h exp=1", k, s0_out_valid); end
            tests++; if (s0_out_data !== 8'hA5) begin fails++; $display("FAIL bp_data[%0d] got=%0h exp=a5", k, s0_out_data); end
            tests++; if (s0_out_src !== 2'd1) begin fails++; $display("FAIL bp_src[%0d] got=%0h exp=1", k, s0_out_src); end
            tests++; if (s0_in_ready !== 4'h0) begin fails++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", k, s0_in_ready); end
            cyc();
        end
        tests++; if (a5_rel !== 0) begin fails++; $display("FAIL bp_early_release got=%0d exp=0", a5_rel); end
        s0_out_ready = 1'b1;
        #1;
        tests++; if (s0_in_ready !== 4'b1000) begin fails++; $display("FAIL bp_free_grant got=%0h exp=8", s0_in_ready); end
        cyc();
        tests++; if (a5_rel !== 1) begin fails++; $display("FAIL bp_release got=%0d exp=1", a5_rel); end
        tests++; if (s0_out_valid !== 1'b1) begin fails++; $display("FAIL bp_replace_valid got=%0h exp=1", s0_out_valid); end
        tests++; if (s0_out_data !== 8'h13) begin fails++; $display("FAIL bp_replace_data got=%0h exp=13", s0_out_data); end
        tests++; if (s0_out_src !== 2'd3) begin fails++; $display("FAIL bp_replace_src got=%0h exp=3", s0_out_src); end
        cyc();
        tests++; if (s0_out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%0h exp=0", s0_out_valid); end
    endtask

    task automatic test_rr();
        s1_in_data = 32'h13121110; s1_out_ready = 1'b1; s1_in_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++; if (s1_in_ready !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_grant[%0d] got=%0h exp=%0h", k, s1_in_ready, 4'(1 << (k % 4))); end
            cyc();
            tests++; if (s1_out_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d] got=%0h exp=1", k, s1_out_valid); end
            tests++; if (s1_out_src !== 2'(k % 4)) begin fails++; $display("FAIL rr_src[%0d] got=%0h exp=%0h", k, s1_out_src, 2'(k % 4)); end
            tests++; if (s1_out_data !== 8'h10 + 8'(k % 4)) begin fails++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", k, s1_out_data, 8'h10 + 8'(k % 4)); end
            tests++; if (s1_sel_err !== 1'b0) begin fails++; $display("FAIL rr_sel_err[%0d] got=%0h exp=0", k, s1_sel_err); end
        end
        s1_in_valid = 4'h0;
        cyc();
        tests++; if (s1_out_valid !== 1'b0) begin fails++; $display("FAIL rr_idle got=%0h exp=0", s1_out_valid); end
    endtask

    task automatic test_rr_wrap();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        s1_in_valid = 4'b1000;
        #1;
        tests++; if (s1_in_ready !== 4'b1000) begin fails++; $display("FAIL wrap_g3 got=%0h exp=8", s1_in_ready); end
        cyc();
        tests++; if (s1_out_src !== 2'd3) begin fails++; $display("FAIL wrap_src3 got=%0h exp=3", s1_out_src); end
        s1_in_valid = 4'b1001;
        #1;
        tests++; if (s1_in_ready !== 4'b0001) begin fails++; $display("FAIL wrap_g0 got=%0h exp=1", s1_in_ready); end
        cyc();
        tests++; if (s1_out_src !== 2'd0) begin fails++; $display("FAIL wrap_src0 got=%0h exp=0", s1_out_src); end
        #1;
        tests++; if (s1_in_ready !== 4'b1000) begin fails++; $display("FAIL wrap_g3b got=%0h exp=8", s1_in_ready); end
        cyc();
        tests++; if (s1_out_src !== 2'd3) begin fails++; $display("FAIL wrap_src3b got=%0h exp=3", s1_out_src); end
        s1_in_valid = 4'h0;
        cyc();
    endtask

    task automatic test_reset_mid();
        s0_out_ready = 1'b0; s0_sel_valid = 1'b1; s0_sel_data = 2'd0;
        s1_out_ready = 1'b0; s1_in_valid = 4'b0010;
        #1;
        tests++; if (s1_in_ready !== 4'b0010) begin fails++; $display("FAIL mid_rr_grant got=%0h exp=2", s1_in_ready); end
        cyc();
        s0_sel_valid = 1'b0; s1_in_valid = 4'h0;
        #1;
        tests++; if (s0_in_ready !== 4'b0001) begin fails++; $display("FAIL mid_grant0 got=%0h exp=1", s0_in_ready); end
        cyc();
        s0_sel_valid = 1'b1; s0_sel_data = 2'd2;
        cyc();
        s0_sel_valid = 1'b0;
        #1;
        tests++; if (s0_out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got=%0h exp=1", s0_out_valid); end
        tests++; if (s0_sel_ready !== 1'b0) begin fails++; $display("FAIL mid_pre_grant got=%0h exp=0", s0_sel_ready); end
        tests++; if (s1_out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_rr_valid got=%0h exp=1", s1_out_valid); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        tests++; if (s0_out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%0h exp=0", s0_out_valid); end
        tests++; if (s0_out_data !== 8'h00) begin fails++; $display("FAIL mid_out_data got=%0h exp=0", s0_out_data); end
        tests++; if (s0_sel_ready !== 1'b1) begin fails++; $display("FAIL mid_idle got=%0h exp=1", s0_sel_ready); end
        tests++; if (s0_in_ready !== 4'h0) begin fails++; $display("FAIL mid_in_ready got=%0h exp=0", s0_in_ready); end
        tests++; if (s1_out_valid !== 1'b0) begin fails++; $display("FAIL mid_rr_valid got=%0h exp=0", s1_out_valid); end
        s1_in_valid = 4'hF; s1_out_ready = 1'b1;
        #1;
        tests++; if (s1_in_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr0 got=%0h exp=1", s1_in_ready); end
        cyc();
        tests++; if (s1_out_src !== 2'd0) begin fails++; $display("FAIL mid_ptr0_src got=%0h exp=0", s1_out_src); end
    endtask

    initial begin
        reset = 1'b1;
        s0_sel_valid = 1'b0; s0_sel_data = 2'd0; s0_in_valid = 4'h0; s0_in_data = '0; s0_out_ready = 1'b1;
        s3_sel_valid = 1'b0; s3_sel_data = 2'd0; s3_in_valid = 3'h0; s3_in_data = '0; s3_out_ready = 1'b1;
        s1_sel_valid = 1'b0; s1_sel_data = 2'd0; s1_in_valid = 4'h0; s1_in_data = '0; s1_out_ready = 1'b1;
        test_reset();
        test_select();
        test_bad_token();
        test_backpressure();
        test_rr();
        test_rr_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
